sdram_ahb_slave: RTL
====================

SDRAM_AHB_SLAVE -- requirements
Module: sdram_ahb_slave

Interface
REQ-001 The block SHALL have parameter AW, default 22, SDRAM word-address width.
REQ-002 The block SHALL have parameter DW, default 32, data width; only 32 is supported.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Ports haddr (in 32), hwdata (in 32), hwrite (in 1), htrans (in 2), hsize (in 3), hburst (in 3), hsel (in 1), hready (in 1): AHB-Lite slave inputs; hburst is ignored.
REQ-007 Ports hrdata (out 32), hreadyout (out 1), hresp (out 1): AHB-Lite slave outputs.
REQ-008 Ports sd_req (out 1), sd_we (out 1), sd_addr (out AW), sd_wdata (out DW), sd_be (out 4): command to the downstream SDRAM controller core.
REQ-009 Ports sd_ack (in 1), sd_rdata (in DW), sd_rvalid (in 1): accept strobe and read return from the SDRAM core.

Function
REQ-010 Address phase accepted when hsel & hready & htrans[1]; haddr, hwrite, hsize latched on that edge.
REQ-011 IDLE/BUSY transfers, and cycles with hsel=0, SHALL get zero-wait OKAY and change no state.
REQ-012 FSM states: IDLE, WDATA, CMD, RDWAIT, ERR1, ERR2.
REQ-013 IDLE -> WDATA on accepted write; IDLE -> CMD on accepted read; hreadyout=1 only in IDLE and ERR2.
REQ-014 WDATA: hreadyout=0; hwdata captured into sd_wdata; -> CMD next cycle.
REQ-015 CMD: sd_req=1, held with stable sd_we/sd_addr/sd_wdata/sd_be until the sd_ack cycle.
REQ-016 On sd_ack in CMD: write -> IDLE; read -> RDWAIT, or IDLE directly if sd_rvalid is also 1 in that cycle.
REQ-017 RDWAIT: sd_req=0; on sd_rvalid, hrdata <= sd_rdata, -> IDLE; hrdata holds until the next read completes.
REQ-018 Minimum latency SHALL be: write 3 cycles and read 2 cycles from address phase to hreadyout=1, with sd_ack (and sd_rvalid) asserted in the first CMD cycle.
REQ-019 sd_addr = haddr[AW+1:2]; sd_we = latched hwrite.
REQ-020 sd_be: byte 4'b0001<<haddr[1:0]; half 4'b0011<<{haddr[1],1'b0}; word 4'b1111.
REQ-021 sd_ack or sd_rvalid outside CMD/RDWAIT SHALL be ignored.
REQ-022 An address phase presented while hreadyout=0 SHALL NOT be accepted (hready is low).

Reset
REQ-023 Reset SHALL force state IDLE, hreadyout=1, hresp=0, hrdata=0, sd_req=0, sd_we=0, sd_addr=0, sd_wdata=0, sd_be=0.
REQ-024 Reset asserted mid-transfer SHALL drop sd_req asynchronously and discard the transfer; a later sd_rvalid is ignored.

Configuration
REQ-025 Macro SDRAM_AHB_SLAVE_ERR_EN, when defined, SHALL enable the ERROR response on accepted transfers that are misaligned (half with haddr[0]=1, word with haddr[1:0]!=0), have hsize>2, or have haddr[31:AW+2]!=0.
REQ-026 With SDRAM_AHB_SLAVE_ERR_EN, an erroring transfer SHALL go IDLE -> ERR1 (hreadyout=0, hresp=1) -> ERR2 (hreadyout=1, hresp=1) -> IDLE, with no sd_req issued.
REQ-027 Without SDRAM_AHB_SLAVE_ERR_EN, hresp SHALL be constant 0, misaligned low address bits SHALL be masked per hsize, hsize>2 SHALL be treated as word, and upper address bits SHALL be ignored.

Verification
REQ-028 Word write haddr=0x0000_0010, hwdata=0xDEADBEEF, sd_ack in first CMD cycle -> sd_req 1 cycle, sd_addr=0x4, sd_be=4'b1111, sd_wdata=0xDEADBEEF, hreadyout=1 three cycles after address phase.
REQ-029 Byte read haddr=0x0000_0003, sd_ack delayed 4 cycles, sd_rvalid 2 cycles later with 0x11223344 -> sd_be=4'b1000, sd_req held 5 cycles, hrdata=0x11223344, hresp=0.
REQ-030 Back-to-back NONSEQ write then read to 0x20 with an idle cycle between -> second address phase accepted only after hreadyout=1; read returns written data from the SDRAM model.
REQ-031 Half-word at haddr=0x2 with ERR_EN -> sd_be=4'b1100, OKAY; half-word at haddr=0x1 -> two-cycle ERROR, sd_req never asserted.
REQ-032 Reset asserted while in CMD with sd_ack withheld -> sd_req=0 same cycle, hreadyout=1; stray sd_rvalid afterwards leaves hrdata=0.

Source files
------------

// File: rtl/sdram_ahb_slave.sv
// ---------------------------------------------------------------------------
// sdram_ahb_slave
//
// AHB-Lite slave front end for an SDRAM controller core. Each accepted AHB
// transfer is turned into a single command (sd_req/sd_we/sd_addr/sd_wdata/
// sd_be). The command is held until the core acknowledges it with sd_ack.
// Read data returns on sd_rvalid and is then presented on hrdata.
//
// Parameters
//   AW : SDRAM word-address width (sd_addr = haddr[AW+1:2])
//   DW : data width, only 32 is supported
//
// Ports
//   clk, rst             : single clock, asynchronous active-high reset
//   haddr .. hready      : AHB-Lite slave inputs (hburst is ignored)
//   hrdata, hreadyout,
//   hresp                : AHB-Lite slave outputs
//   sd_req .. sd_be      : command towards the SDRAM core
//   sd_ack, sd_rdata,
//   sd_rvalid            : command accept strobe and read return from the core
//
// Configuration
//   SDRAM_AHB_SLAVE_ERR_EN : when defined, misaligned transfers, hsize > 2 and
//                            addresses beyond the SDRAM get a two-cycle ERROR
//                            response. When undefined, hresp is tied to 0,
//                            misaligned low address bits are masked, hsize > 2
//                            is handled as a word and upper address bits are
//                            ignored.
// ---------------------------------------------------------------------------
module sdram_ahb_slave #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   haddr,
    input  logic [31:0]   hwdata,
    input  logic          hwrite,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic          hsel,
    input  logic          hready,
    output logic [31:0]   hrdata,
    output logic          hreadyout,
    output logic          hresp,
    output logic          sd_req,
    output logic          sd_we,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_wdata,
    output logic [3:0]    sd_be,
    input  logic          sd_ack,
    input  logic [DW-1:0] sd_rdata,
    input  logic          sd_rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        CMD,
        RDWAIT,
        ERR1,
        ERR2
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [31:0]     hrdata_q, hrdata_d;

    logic            accept;
    logic            xferErr;
    logic            readDone;
    logic [3:0]      byteEn;
    logic            unusedBits;

    // hburst and htrans[0] carry no meaning for a single-beat slave, and the
    // upper address bits only matter in the error-checking build. Folding them
    // into one named signal documents that they are deliberately left unused.
    assign unusedBits = ^{hburst, htrans[0], haddr};

    // A new address phase is only taken when the previous data phase is
    // completing on this slave, i.e. in IDLE or in the last ERROR cycle. In
    // every other state the master sees hready low, so even a NONSEQ on the
    // bus is still waiting and must not be sampled.
    assign accept = hsel && hready && htrans[1] &&
                    ((state_q == IDLE) || (state_q == ERR2));

    // Read data is taken either in the acknowledge cycle itself (core answers
    // immediately) or later while waiting in RDWAIT. A stray sd_rvalid in any
    // other state is ignored.
    assign readDone = ((state_q == CMD) && sd_ack && !we_q && sd_rvalid) ||
                      ((state_q == RDWAIT) && sd_rvalid);

    // Byte lane enables from the transfer size. The shift amounts only use the
    // address bits that are meaningful for that size, so misaligned low bits
    // are masked off naturally; any size above a word is treated as a word.
    always_comb begin
        byteEn = 4'b1111;
        case (hsize)
            3'd0:    byteEn = 4'b0001 << haddr[1:0];
            3'd1:    byteEn = 4'b0011 << {haddr[1], 1'b0};
            default: byteEn = 4'b1111;
        endcase
    end

`ifdef SDRAM_AHB_SLAVE_ERR_EN
    // Transfers the SDRAM cannot represent faithfully are rejected: oversize
    // beats, misaligned halves and words, and addresses above the SDRAM.
    always_comb begin
        xferErr = 1'b0;
        if (hsize > 3'd2) begin
            xferErr = 1'b1;
        end
        if ((hsize == 3'd1) && haddr[0]) begin
            xferErr = 1'b1;
        end
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
            xferErr = 1'b1;
        end
        if ((haddr >> (AW + 2)) != '0) begin
            xferErr = 1'b1;
        end
    end
`else
    // Without error checking every accepted transfer is forwarded.
    assign xferErr = 1'b0;
`endif

    // State register. Reset drops straight back to IDLE, which removes sd_req
    // immediately and abandons whatever transfer was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. hreadyout is high only when a data
    // phase is finishing (IDLE or the second ERROR cycle); sd_req is high for
    // exactly the cycles spent in CMD, so it stays asserted until sd_ack.
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b0;
        hresp     = 1'b0;
        sd_req    = 1'b0;
        case (state_q)
            IDLE, ERR2: begin
                hreadyout = 1'b1;
                state_d   = IDLE;
                if (accept) begin
                    if (xferErr) begin
                        state_d = ERR1;
                    end else if (hwrite) begin
                        state_d = WDATA;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            WDATA: begin
                state_d = CMD;
            end
            CMD: begin
                sd_req = 1'b1;
                if (sd_ack) begin
                    if (we_q || sd_rvalid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (sd_rvalid) begin
                    state_d = IDLE;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SDRAM_AHB_SLAVE_ERR_EN
        hresp = (state_q == ERR1) || (state_q == ERR2);
`endif
    end

    // Command fields are captured with the address phase and then left alone,
    // so they are stable for the whole time sd_req is high. Write data is
    // taken during the AHB data phase (WDATA), one cycle after the address.
    // hrdata only moves when a read completes and otherwise holds.
    always_comb begin
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        hrdata_d = hrdata_q;
        if (accept && !xferErr) begin
            we_d   = hwrite;
            addr_d = haddr[AW+1:2];
            be_d   = byteEn;
        end
        if (state_q == WDATA) begin
            wdata_d = DW'(hwdata);
        end
        if (readDone) begin
            hrdata_d = 32'(sd_rdata);
        end
    end

    // Datapath registers, all cleared by reset so the command bus is quiet
    // and hrdata reads zero until the first read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            hrdata_q <= 32'd0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign sd_we    = we_q;
    assign sd_addr  = addr_q;
    assign sd_be    = be_q;
    assign sd_wdata = wdata_q;
    assign hrdata   = hrdata_q;

endmodule
